// File: rtl/mac_grp_ts_fifo.sv
// mac_grp_ts_fifo
// Buffers 64-bit {Time_HI, Time_LO} timestamps from the time-stamp stage
// until the register/host side pops them. First-word-fall-through: the head
// entry is always presented on rd_ts_*, and rd_ts_* read as zero while empty.
// Timestamps arriving while full, with no pop in the same cycle, are dropped.
// Dropped timestamps are counted with saturation and flagged with a sticky
// overflow bit.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous active-high reset
//   ts_hi/ts_lo  in   timestamp words, qualified by ts_valid
//   ts_valid     in   one-cycle write strobe
//   rd_en        in   pop request, ignored while empty
//   rd_ts_hi/lo  out  head entry, zero when empty
//   rd_empty     out  FIFO holds no entries
//   fifo_count   out  stored entries, 0..DEPTH
//   drop_count   out  saturating count of dropped timestamps
//   overflow     out  sticky, at least one drop since the last clear
//   clear_stats  in   clears drop_count and overflow
module mac_grp_ts_fifo #(
  parameter int DEPTH_BITS     = 3,
  parameter int DROP_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               ts_hi,
  input  logic [31:0]               ts_lo,
  input  logic                      ts_valid,
  input  logic                      rd_en,
  output logic [31:0]               rd_ts_hi,
  output logic [31:0]               rd_ts_lo,
  output logic                      rd_empty,
  output logic [DEPTH_BITS:0]       fifo_count,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      overflow,
  input  logic                      clear_stats
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]       FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]       CNT_ONE  = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0]     PTR_ONE  = DEPTH_BITS'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

  logic [63:0]               r_mem [DEPTH];
  logic [DEPTH_BITS-1:0]     r_wr_ptr;
  logic [DEPTH_BITS-1:0]     r_rd_ptr;
  logic [DEPTH_BITS:0]       r_count;
  logic [DROP_CNT_WIDTH-1:0] r_drop_count;
  logic                      r_overflow;

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [63:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = rd_en && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = ts_valid && (!w_full || w_pop);
  assign w_drop  = ts_valid && w_full && !w_pop;

  // Storage is not reset; entries are only observable through r_count.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= {ts_hi, ts_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // A drop coincident with clear_stats is counted after the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else if (clear_stats) begin
      r_drop_count <= w_drop ? DROP_ONE : '0;
      r_overflow   <= w_drop;
    end else if (w_drop) begin
      if (r_drop_count != DROP_MAX) begin
        r_drop_count <= r_drop_count + DROP_ONE;
      end
      r_overflow <= 1'b1;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign rd_ts_hi   = w_empty ? 32'h0 : w_head[63:32];
  assign rd_ts_lo   = w_empty ? 32'h0 : w_head[31:0];
  assign rd_empty   = w_empty;
  assign fifo_count = r_count;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_mac_grp_ts_fifo.sv
// Randomised and directed bench for mac_grp_ts_fifo against a queue-based
// reference model. DROP_CNT_WIDTH is reduced so saturation is reachable.
module tb_mac_grp_ts_fifo;

  localparam int DB    = 3;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << DB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   ts_hi = '0;
  logic [31:0]   ts_lo = '0;
  logic          ts_valid = 1'b0;
  logic          rd_en = 1'b0;
  logic          clear_stats = 1'b0;
  logic [31:0]   rd_ts_hi;
  logic [31:0]   rd_ts_lo;
  logic          rd_empty;
  logic [DB:0]   fifo_count;
  logic [DW-1:0] drop_count;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_q[$];
  int          m_drop = 0;
  bit          m_ovf = 1'b0;

  mac_grp_ts_fifo #(
    .DEPTH_BITS    (DB),
    .DROP_CNT_WIDTH(DW)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .ts_hi      (ts_hi),
    .ts_lo      (ts_lo),
    .ts_valid   (ts_valid),
    .rd_en      (rd_en),
    .rd_ts_hi   (rd_ts_hi),
    .rd_ts_lo   (rd_ts_lo),
    .rd_empty   (rd_empty),
    .fifo_count (fifo_count),
    .drop_count (drop_count),
    .overflow   (overflow),
    .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge with the given inputs.
  task automatic model(input bit rst, input bit v, input logic [63:0] d, input bit rd,
                       input bit clr);
    bit was_full;
    bit popped;
    bit dropped;
    if (rst) begin
      m_q.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
      return;
    end
    was_full = (m_q.size() == DEPTH);
    popped   = rd && (m_q.size() > 0);
    dropped  = v && was_full && !popped;
    if (popped) void'(m_q.pop_front());
    if (v && !dropped) m_q.push_back(d);
    if (clr) begin
      m_drop = 0;
      m_ovf  = 1'b0;
    end
    if (dropped) begin
      if (m_drop < (1 << DW) - 1) m_drop++;
      m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [63:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 64'h0;
    chk({tag, ".count"}, 64'(fifo_count), 64'(m_q.size()));
    chk({tag, ".empty"}, 64'(rd_empty), 64'(m_q.size() == 0));
    chk({tag, ".hi"}, 64'(rd_ts_hi), 64'(head[63:32]));
    chk({tag, ".lo"}, 64'(rd_ts_lo), 64'(head[31:0]));
    chk({tag, ".drop"}, 64'(drop_count), 64'(m_drop));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
  endtask

  task automatic step(input string tag, input bit rst, input bit v, input logic [31:0] hi,
                      input logic [31:0] lo, input bit rd, input bit clr);
    reset       = rst;
    ts_valid    = v;
    ts_hi       = hi;
    ts_lo       = lo;
    rd_en       = rd;
    clear_stats = clr;
    model(rst, v, {hi, lo}, rd, clr);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step("rst", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("rst2", 1'b1, 1'b1, 32'hdead, 32'hbeef, 1'b1, 1'b1);
    chk("rst_count_const", 64'(fifo_count), 64'd0);
    idle("idle0");

    // Single write then pop
    step("w1", 1'b0, 1'b1, 32'h00000001, 32'h89ABCDEF, 1'b0, 1'b0);
    chk("w1_lo_const", 64'(rd_ts_lo), 64'h89ABCDEF);
    chk("w1_cnt_const", 64'(fifo_count), 64'd1);
    step("p1", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("p1_lo_const", 64'(rd_ts_lo), 64'd0);
    step("p_empty", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill, drop one, then write+pop while full
    for (int i = 1; i <= 8; i++) step("fill", 1'b0, 1'b1, 32'h0, 32'(i), 1'b0, 1'b0);
    chk("full_cnt_const", 64'(fifo_count), 64'd8);
    step("drop9", 1'b0, 1'b1, 32'h0, 32'd9, 1'b0, 1'b0);
    chk("drop9_const", 64'(drop_count), 64'd1);
    step("full_wp", 1'b0, 1'b1, 32'h0, 32'h55, 1'b1, 1'b0);
    chk("full_wp_cnt_const", 64'(fifo_count), 64'd8);
    chk("full_wp_head_const", 64'(rd_ts_lo), 64'd2);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("clr", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Pointer wrap with alternating write/pop
    for (int i = 0; i < 20; i++) begin
      step("wrap_w", 1'b0, 1'b1, 32'(i * 3), 32'(100 + i), 1'b0, 1'b0);
      step("wrap_p", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    // Clear coincident with a drop
    for (int i = 0; i < 11; i++) step("fill2", 1'b0, 1'b1, 32'h1, 32'(200 + i), 1'b0, 1'b0);
    chk("drop3_const", 64'(drop_count), 64'd3);
    step("clr_drop", 1'b0, 1'b1, 32'h1, 32'h300, 1'b0, 1'b1);
    chk("clr_drop_const", 64'(drop_count), 64'd1);
    step("clr_only", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("clr_only_ovf_const", 64'(overflow), 64'd0);

    // Saturation of the drop counter
    for (int i = 0; i < 20; i++) step("sat", 1'b0, 1'b1, 32'h2, 32'(i), 1'b0, 1'b0);
    chk("sat_const", 64'(drop_count), 64'hF);

    // Reset mid-operation with a write pending
    step("rst3", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("fill5", 1'b0, 1'b1, 32'h3, 32'(i), 1'b0, 1'b0);
    step("rst_wv", 1'b1, 1'b1, 32'h3, 32'h77, 1'b0, 1'b0);
    chk("rst_wv_cnt_const", 64'(fifo_count), 64'd0);

    // Write and pop while empty: pop ignored
    step("empty_wp", 1'b0, 1'b1, 32'h4, 32'h88, 1'b1, 1'b0);
    chk("empty_wp_cnt_const", 64'(fifo_count), 64'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      bit v;
      bit rd;
      bit clr;
      rst = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 49) == 0);
      step("rand", rst, v, $urandom, $urandom, rd, clr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac_grp_ts_fifo.md
MAC_GRP_TS_FIFO -- requirements
Module: mac_grp_ts_fifo

Interface
REQ-001 Parameter DEPTH_BITS, default 3, log2 of FIFO depth (DEPTH = 2**DEPTH_BITS entries).
REQ-002 Parameter DROP_CNT_WIDTH, default 32, width of the dropped-timestamp counter.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port ts_hi  input  32  upper timestamp word from time-stamp stage (Time_HI).
REQ-006 Port ts_lo  input  32  lower timestamp word from time-stamp stage (Time_LO).
REQ-007 Port ts_valid  input  1  one-cycle strobe, ts_hi/ts_lo valid; may assert on consecutive cycles.
REQ-008 Port rd_en  input  1  pop request from register/host side.
REQ-009 Port rd_ts_hi  output  32  head entry upper word (first-word-fall-through).
REQ-010 Port rd_ts_lo  output  32  head entry lower word.
REQ-011 Port rd_empty  output  1  FIFO holds no entries.
REQ-012 Port fifo_count  output  DEPTH_BITS+1  number of stored entries, 0..DEPTH.
REQ-013 Port drop_count  output  DROP_CNT_WIDTH  timestamps discarded because FIFO full.
REQ-014 Port overflow  output  1  sticky flag, at least one drop since last clear.
REQ-015 Port clear_stats  input  1  one-cycle pulse clearing drop_count and overflow.

Function
REQ-016 Storage: DEPTH entries x 64 bits {ts_hi, ts_lo}; write/read pointers DEPTH_BITS wide, wrap modulo DEPTH.
REQ-017 Write: ts_valid=1 and (fifo_count<DEPTH or rd_en pops same cycle) -> store at wr_ptr, wr_ptr+1.
REQ-018 Read: rd_en=1 and rd_empty=0 -> rd_ptr+1; rd_en while rd_empty=1 ignored, no pointer/count change.
REQ-019 FWFT: rd_ts_hi/rd_ts_lo reflect entry at rd_ptr whenever rd_empty=0; both drive 0 when rd_empty=1.
REQ-020 Latency: entry written at edge N visible on rd_ts_* and rd_empty=0 after edge N (usable cycle N+1); no combinational path ts_* -> rd_ts_*.
REQ-021 fifo_count registered: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop or neither.
REQ-022 rd_empty = (fifo_count==0), registered-consistent with fifo_count.
REQ-023 Full (fifo_count==DEPTH) with ts_valid=1 and rd_en=1: pop and write both performed, count stays DEPTH, no drop.
REQ-024 Full with ts_valid=1 and rd_en=0: timestamp discarded, stored contents unchanged, drop_count+1, overflow<=1.
REQ-025 drop_count saturates at all-ones; no wrap.
REQ-026 clear_stats=1: drop_count<=0, overflow<=0; if a drop occurs same cycle, result drop_count=1, overflow=1.
REQ-027 clear_stats does not affect FIFO contents, pointers or fifo_count.
REQ-028 Empty with ts_valid=1 and rd_en=1 same cycle: rd_en ignored, write accepted, count becomes 1.

Reset
REQ-029 reset=1 at a rising edge: wr_ptr=0, rd_ptr=0, fifo_count=0, rd_empty=1, rd_ts_hi=0, rd_ts_lo=0, drop_count=0, overflow=0.
REQ-030 reset has priority over ts_valid, rd_en and clear_stats in the same cycle; inputs in that cycle have no effect.
REQ-031 reset mid-operation discards all stored entries; storage array contents need not be cleared but are unobservable.

Verification
REQ-032 Reset then single ts_valid with ts_hi=0x00000001, ts_lo=0x89ABCDEF -> next cycle rd_empty=0, fifo_count=1, rd_ts_hi=0x00000001, rd_ts_lo=0x89ABCDEF; rd_en pulse -> rd_empty=1, rd_ts_*=0.
REQ-033 8 consecutive ts_valid cycles with ts_lo=1..8 (DEPTH_BITS=3) -> fifo_count=8; 9th write (ts_lo=9) -> drop_count=1, overflow=1; 8 pops return ts_lo=1..8 in order.
REQ-034 Full FIFO, ts_valid (ts_lo=0x55) and rd_en same cycle -> fifo_count=8, drop_count unchanged, head advances, 0x55 read last.
REQ-035 Pointer wrap: 20 alternating write/pop pairs with ts_lo=incrementing -> every pop returns matching value, fifo_count toggles 1/0, no drops.
REQ-036 Overflowed state (drop_count=3), clear_stats coincident with a drop -> drop_count=1, overflow=1; clear_stats alone next -> drop_count=0, overflow=0, fifo_count unchanged.
REQ-037 Reset asserted with fifo_count=5 and ts_valid=1 -> next cycle fifo_count=0, rd_empty=1, drop_count=0.
